// File: rtl/ram_2p_cfg.sv
// Parametrised true dual-port RAM with read-first semantics, port-A write priority
// on same-word collisions, optional output register stage and a sticky collision flag.

module ram_2p_cfg_chk #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 128
) (
   input logic clk_i,
   input logic rst_ni,
   input logic a_req_i,
   input logic a_we_i,
   input logic b_req_i,
   input logic b_we_i,
   input logic a_rvalid_i,
   input logic b_rvalid_i
);

   if ((Width % 32'd8 != 32'd0) || (Width < 32'd8)) begin : g_bad_width
      $error("ram_2p_cfg: Width must be a multiple of 8 and at least 8");
   end
   if ((Depth < 32'd2) || ((Depth & (Depth - 32'd1)) != 32'd0)) begin : g_bad_depth
      $error("ram_2p_cfg: Depth must be a power of two and at least 2");
   end

   // Request controls must be known whenever the block is out of reset
   req_known_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !$isunknown({a_req_i, a_we_i, b_req_i, b_we_i}));

   // Response valids must be known once reset has been released
   rvalid_known_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !$isunknown({a_rvalid_i, b_rvalid_i}));

endmodule

module ram_2p_cfg #(
   parameter int unsigned Width       = 32,
   parameter int unsigned Depth       = 128,
   parameter int unsigned OutputReg   = 0,
   parameter string       MemInitFile = ""
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 a_req_i,
   input  logic                 a_we_i,
   input  logic [Width/8-1:0]   a_be_i,
   input  logic [31:0]          a_addr_i,
   input  logic [Width-1:0]     a_wdata_i,
   output logic                 a_rvalid_o,
   output logic [Width-1:0]     a_rdata_o,
   input  logic                 b_req_i,
   input  logic                 b_we_i,
   input  logic [Width/8-1:0]   b_be_i,
   input  logic [31:0]          b_addr_i,
   input  logic [Width-1:0]     b_wdata_i,
   output logic                 b_rvalid_o,
   output logic [Width-1:0]     b_rdata_o,
   output logic                 collision_o
);

   localparam int unsigned NumBytes = Width / 8;
   localparam int unsigned Ab       = $clog2(NumBytes);
   localparam int unsigned Aw       = $clog2(Depth);

   logic [Width-1:0] mem_r [Depth];

   logic [Aw-1:0]    a_idx_s;
   logic [Aw-1:0]    b_idx_s;
   logic             a_wr_s;
   logic             b_wr_s;
   logic             collide_s;
   logic             unused_addr_s;

   logic             a_valid1_r;
   logic             b_valid1_r;
   logic [Width-1:0] a_rdata1_r;
   logic [Width-1:0] b_rdata1_r;
   logic             collision_r;

   assign a_idx_s       = a_addr_i[Aw+Ab-1:Ab];
   assign b_idx_s       = b_addr_i[Aw+Ab-1:Ab];
   assign a_wr_s        = a_req_i & a_we_i;
   assign b_wr_s        = b_req_i & b_we_i;
   assign collide_s     = a_wr_s & b_wr_s & (a_idx_s == b_idx_s) & (|(a_be_i & b_be_i));
   assign unused_addr_s = ^{a_addr_i, b_addr_i};

   // Array update: B is applied first so A's later assignment wins on shared bytes
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NumBytes; i++) begin
         if (b_wr_s && b_be_i[i]) begin
            mem_r[b_idx_s][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
         end
         if (a_wr_s && a_be_i[i]) begin
            mem_r[a_idx_s][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
         end
      end
   end

   // First response stage: samples the pre-write word, holds data when idle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_valid1_r <= 1'b0;
         b_valid1_r <= 1'b0;
         a_rdata1_r <= {Width{1'b0}};
         b_rdata1_r <= {Width{1'b0}};
      end else begin
         a_valid1_r <= a_req_i;
         b_valid1_r <= b_req_i;
         if (a_req_i) begin
            a_rdata1_r <= mem_r[a_idx_s];
         end
         if (b_req_i) begin
            b_rdata1_r <= mem_r[b_idx_s];
         end
      end
   end

   // Sticky same-word, same-byte write/write collision flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         collision_r <= 1'b0;
      end else if (collide_s) begin
         collision_r <= 1'b1;
      end
   end

   if (OutputReg != 32'd0) begin : g_out_reg
      logic             a_valid2_r;
      logic             b_valid2_r;
      logic [Width-1:0] a_rdata2_r;
      logic [Width-1:0] b_rdata2_r;

      // Second response stage: forwards stage-1 valid, captures data only with it
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            a_valid2_r <= 1'b0;
            b_valid2_r <= 1'b0;
            a_rdata2_r <= {Width{1'b0}};
            b_rdata2_r <= {Width{1'b0}};
         end else begin
            a_valid2_r <= a_valid1_r;
            b_valid2_r <= b_valid1_r;
            if (a_valid1_r) begin
               a_rdata2_r <= a_rdata1_r;
            end
            if (b_valid1_r) begin
               b_rdata2_r <= b_rdata1_r;
            end
         end
      end

      assign a_rvalid_o = a_valid2_r;
      assign b_rvalid_o = b_valid2_r;
      assign a_rdata_o  = a_rdata2_r;
      assign b_rdata_o  = b_rdata2_r;
   end else begin : g_no_out_reg
      assign a_rvalid_o = a_valid1_r;
      assign b_rvalid_o = b_valid1_r;
      assign a_rdata_o  = a_rdata1_r;
      assign b_rdata_o  = b_rdata1_r;
   end

   assign collision_o = collision_r;

   ram_2p_cfg_chk #(
      .Width (Width),
      .Depth (Depth)
   ) u_chk (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .a_req_i    (a_req_i),
      .a_we_i     (a_we_i),
      .b_req_i    (b_req_i),
      .b_we_i     (b_we_i),
      .a_rvalid_i (a_rvalid_o),
      .b_rvalid_i (b_rvalid_o)
   );

endmodule

// File: tb/tb_ram_2p_cfg.sv
// Scoreboard bench: two configurations (32-bit/latency 1 and 64-bit/latency 2) share
// one stimulus stream; a behavioural memory model predicts every response.

module tb_ram_2p_cfg;

   localparam int NEVER = 32'h7FFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b1;
   logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [7:0]  a_be = '0, b_be = '0;
   logic [31:0] a_addr = '0, b_addr = '0;
   logic [63:0] a_wdata = '0, b_wdata = '0;

   logic        d0_a_rvalid, d0_b_rvalid, d0_coll;
   logic [31:0] d0_a_rdata, d0_b_rdata;
   logic        d1_a_rvalid, d1_b_rvalid, d1_coll;
   logic [63:0] d1_a_rdata, d1_b_rdata;

   always #5 clk = ~clk;

   ram_2p_cfg #(.Width(32), .Depth(128), .OutputReg(0), .MemInitFile("")) u_d0 (
      .clk_i(clk), .rst_ni(rst_ni),
      .a_req_i(a_req), .a_we_i(a_we), .a_be_i(a_be[3:0]), .a_addr_i(a_addr),
      .a_wdata_i(a_wdata[31:0]), .a_rvalid_o(d0_a_rvalid), .a_rdata_o(d0_a_rdata),
      .b_req_i(b_req), .b_we_i(b_we), .b_be_i(b_be[3:0]), .b_addr_i(b_addr),
      .b_wdata_i(b_wdata[31:0]), .b_rvalid_o(d0_b_rvalid), .b_rdata_o(d0_b_rdata),
      .collision_o(d0_coll));

   ram_2p_cfg #(.Width(64), .Depth(64), .OutputReg(1), .MemInitFile("")) u_d1 (
      .clk_i(clk), .rst_ni(rst_ni),
      .a_req_i(a_req), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr),
      .a_wdata_i(a_wdata), .a_rvalid_o(d1_a_rvalid), .a_rdata_o(d1_a_rdata),
      .b_req_i(b_req), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr),
      .b_wdata_i(b_wdata), .b_rvalid_o(d1_b_rvalid), .b_rdata_o(d1_b_rdata),
      .collision_o(d1_coll));

   typedef struct {
      logic [63:0] data;
      int          cyc;
      bit          chk;
   } exp_t;

   // queue index: 0 = d0 port A, 1 = d0 port B, 2 = d1 port A, 3 = d1 port B
   exp_t        q0[$], q1[$], q2[$], q3[$];
   logic [63:0] m0 [128];
   logic [63:0] m1 [64];
   logic [63:0] last [4];
   int          coll_cyc [2];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   bit          chk_data = 1'b0;

   function automatic logic [63:0] mrd(int d, int i);
      if (d == 0) return m0[i];
      return m1[i];
   endfunction

   function automatic void mwr(int d, int i, logic [63:0] v);
      if (d == 0) m0[i] = v;
      else m1[i] = v;
   endfunction

   function automatic void push(int p, exp_t e);
      case (p)
         0: q0.push_back(e);
         1: q1.push_back(e);
         2: q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endfunction

   function automatic int qsize(int p);
      case (p)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return q3.size();
      endcase
   endfunction

   function automatic exp_t pop(int p);
      case (p)
         0: return q0.pop_front();
         1: return q1.pop_front();
         2: return q2.pop_front();
         default: return q3.pop_front();
      endcase
   endfunction

   function automatic int front_cyc(int p);
      case (p)
         0: return q0[0].cyc;
         1: return q1[0].cyc;
         2: return q2[0].cyc;
         default: return q3[0].cyc;
      endcase
   endfunction

   // Reference model: word index = (byte address / bytes per word) mod depth,
   // both ports read the old word, A's bytes beat B's bytes on a shared word.
   function automatic void model_step();
      for (int d = 0; d < 2; d++) begin
         int nb  = (d == 0) ? 4 : 8;
         int dep = (d == 0) ? 128 : 64;
         int lat = (d == 0) ? 1 : 2;
         int ia  = int'((a_addr / nb) % dep);
         int ib  = int'((b_addr / nb) % dep);
         bit aw  = a_req && a_we;
         bit bw  = b_req && b_we;
         bit ovl = 1'b0;
         logic [63:0] w;
         if (a_req) push(2*d,   '{mrd(d, ia), cyc + lat, chk_data});
         if (b_req) push(2*d+1, '{mrd(d, ib), cyc + lat, chk_data});
         for (int j = 0; j < nb; j++) begin
            if (aw && bw && ia == ib && a_be[j] && b_be[j]) ovl = 1'b1;
            if (bw && b_be[j] && !(aw && ia == ib && a_be[j])) begin
               w = mrd(d, ib);
               w[8*j +: 8] = b_wdata[8*j +: 8];
               mwr(d, ib, w);
            end
            if (aw && a_be[j]) begin
               w = mrd(d, ia);
               w[8*j +: 8] = a_wdata[8*j +: 8];
               mwr(d, ia, w);
            end
         end
         if (ovl && coll_cyc[d] > cyc + 1) coll_cyc[d] = cyc + 1;
      end
   endfunction

   task automatic apply(input bit ar, input bit aw, input logic [7:0] abe,
                        input logic [31:0] aad, input logic [63:0] awd,
                        input bit br, input bit bw, input logic [7:0] bbe,
                        input logic [31:0] bad, input logic [63:0] bwd);
      a_req = ar; a_we = aw; a_be = abe; a_addr = aad; a_wdata = awd;
      b_req = br; b_we = bw; b_be = bbe; b_addr = bad; b_wdata = bwd;
      model_step();
   endtask

   task automatic step(input bit ar, input bit aw, input logic [7:0] abe,
                       input logic [31:0] aad, input logic [63:0] awd,
                       input bit br, input bit bw, input logic [7:0] bbe,
                       input logic [31:0] bad, input logic [63:0] bwd);
      @(posedge clk);
      #1;
      apply(ar, aw, abe, aad, awd, br, bw, bbe, bad, bwd);
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 8'h0, 32'h0, 64'h0, 0, 0, 8'h0, 32'h0, 64'h0);
   endtask

   task automatic mon_port(input int p, input logic rv, input logic [63:0] rd);
      exp_t e;
      checks++;
      if (!rst_ni) begin
         if (rv !== 1'b0 || rd !== 64'h0) begin
            errors++;
            $display("FAIL reset_out p%0d: rvalid=%0b rdata=%h, required 0 and 0", p, rv, rd);
         end
         last[p] = 64'h0;
      end else if (rv) begin
         if (qsize(p) == 0) begin
            errors++;
            $display("FAIL unexpected_rvalid p%0d cyc %0d: rvalid=1, required 0", p, cyc);
         end else begin
            e = pop(p);
            if (e.cyc != cyc) begin
               errors++;
               $display("FAIL latency p%0d: response at cyc %0d, required cyc %0d", p, cyc, e.cyc);
            end else if (e.chk && rd !== e.data) begin
               errors++;
               $display("FAIL rdata p%0d cyc %0d: got %h, required %h", p, cyc, rd, e.data);
            end
         end
         last[p] = rd;
      end else begin
         if (rd !== last[p]) begin
            errors++;
            $display("FAIL rdata_hold p%0d cyc %0d: got %h, required %h", p, cyc, rd, last[p]);
         end
         if (qsize(p) != 0 && front_cyc(p) <= cyc) begin
            e = pop(p);
            errors++;
            $display("FAIL missing_rvalid p%0d: rvalid=0 at cyc %0d, required 1 (due cyc %0d)", p, cyc, e.cyc);
         end
      end
   endtask

   task automatic mon_coll(input int d, input logic c);
      logic expv;
      expv = rst_ni && (cyc >= coll_cyc[d]);
      checks++;
      if (c !== expv) begin
         errors++;
         $display("FAIL collision d%0d cyc %0d: got %0b, required %0b", d, cyc, c, expv);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: samples all outputs on the falling edge, away from the active edge
   initial forever begin
      @(negedge clk);
      mon_port(0, d0_a_rvalid, {32'h0, d0_a_rdata});
      mon_port(1, d0_b_rvalid, {32'h0, d0_b_rdata});
      mon_port(2, d1_a_rvalid, d1_a_rdata);
      mon_port(3, d1_b_rvalid, d1_b_rdata);
      mon_coll(0, d0_coll);
      mon_coll(1, d1_coll);
   end

   task automatic do_reset(input int n);
      a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
      rst_ni = 1'b0;
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
      coll_cyc[0] = NEVER; coll_cyc[1] = NEVER;
      for (int i = 0; i < 4; i++) last[i] = 64'h0;
      repeat (n) @(posedge clk);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) m0[i] = 64'h0;
      for (int i = 0; i < 64; i++) m1[i] = 64'h0;
      #1;
      do_reset(3);
      #1;
      rst_ni = 1'b1;

      // Clear both arrays; old contents are unknown so those responses skip data
      chk_data = 1'b0;
      for (int i = 0; i < 64; i++)
         step(1, 1, 8'hFF, i*4, 64'h0, 1, 1, 8'hFF, (i+64)*4, 64'h0);
      idle(3);
      chk_data = 1'b1;

      // Write then cross-port read
      step(1, 1, 8'h0F, 32'h10, 64'hDEADBEEF, 0, 0, 8'h0, 32'h0, 64'h0);
      step(0, 0, 8'h0, 32'h0, 64'h0, 1, 0, 8'h0, 32'h10, 64'h0);
      // Partial byte-enable write then read
      step(1, 1, 8'h0F, 32'h08, 64'h1122334455667788, 0, 0, 8'h0, 32'h0, 64'h0);
      step(1, 0, 8'h0, 32'h08, 64'h0, 0, 0, 8'h0, 32'h0, 64'h0);
      // Same-word write/write with overlapping byte 1
      step(1, 1, 8'h03, 32'h20, 64'hAAAAAAAAAAAAAAAA, 1, 1, 8'h06, 32'h20, 64'hBBBBBBBBBBBBBBBB);
      idle(10);
      step(1, 0, 8'h0, 32'h20, 64'h0, 0, 0, 8'h0, 32'h0, 64'h0);
      // Read-during-write across ports, then re-read
      step(1, 1, 8'hFF, 32'h04, 64'h12345678, 0, 0, 8'h0, 32'h0, 64'h0);
      step(1, 1, 8'hFF, 32'h04, 64'hCAFEF00D, 1, 0, 8'h0, 32'h04, 64'h0);
      step(0, 0, 8'h0, 32'h0, 64'h0, 1, 0, 8'h0, 32'h04, 64'h0);
      // Aliasing and a burst of back-to-back reads
      step(1, 1, 8'hFF, 32'h200, 64'h5, 0, 0, 8'h0, 32'h0, 64'h0);
      step(1, 0, 8'h0, 32'h000, 64'h0, 0, 0, 8'h0, 32'h0, 64'h0);
      for (int i = 0; i < 8; i++)
         step(1, 0, 8'h0, i*4, 64'h0, 0, 0, 8'h0, 32'h0, 64'h0);

      // Reset one cycle after reads are issued; release with a request
      step(1, 0, 8'h0, 32'h10, 64'h0, 1, 0, 8'h0, 32'h20, 64'h0);
      @(posedge clk);
      #1;
      do_reset(3);
      #1;
      rst_ni = 1'b1;
      apply(1, 0, 8'h0, 32'h10, 64'h0, 1, 0, 8'h0, 32'h20, 64'h0);
      idle(3);

      // Zero byte-enable and disjoint-byte same-word writes: no collision
      step(1, 1, 8'h00, 32'h30, 64'h1111111111111111, 1, 1, 8'h00, 32'h30, 64'h2222222222222222);
      step(1, 1, 8'h03, 32'h30, 64'h3333333333333333, 1, 1, 8'h0C, 32'h30, 64'h4444444444444444);
      step(1, 0, 8'h0, 32'h30, 64'h0, 1, 0, 8'h0, 32'h34, 64'h0);
      idle(3);

      // Randomised traffic focused on a few words, random upper address bits
      for (int i = 0; i < 400; i++) begin
         logic [31:0] aa, ba;
         aa = ($urandom & 32'hFFFF_FE00) | ($urandom_range(0, 7) * 8) | ($urandom & 32'h7);
         ba = ($urandom & 32'hFFFF_FE00) | ($urandom_range(0, 7) * 8) | ($urandom & 32'h7);
         step(($urandom % 4) != 0, $urandom % 2, 8'($urandom), aa, {$urandom, $urandom},
              ($urandom % 4) != 0, $urandom % 2, 8'($urandom), ba, {$urandom, $urandom});
      end
      idle(6);

      checks++;
      if (q0.size() + q1.size() + q2.size() + q3.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d responses outstanding, required 0",
                  q0.size() + q1.size() + q2.size() + q3.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
